truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequential controller that drives a 4-input combinational function block through all 16 input vectors and captures its two outputs into 16-bit truth-table registers. It sits beside the combinational block under test, such as the lab SOP/POS function pairs. It supplies W/X/Y/Z, waits a programmable settle time per vector, and samples the two function outputs. With comparison compiled in, it also reports whether the two outputs implement the same function.

## Interface
Parameters:
- SETTLE_CYC, 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  synchronous abort of a running sweep.
- f1  in  1  first function output of the block under test.
- f2  in  1  second function output of the block under test.
- w, x, y, z  out  1 each  applied vector; {w,x,y,z} = idx, with w as MSB.
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  one-cycle pulse when a sweep completes.
- tt1  out  16  f1 truth table; bit i = f1 at idx i.
- tt2  out  16  f2 truth table; bit i = f2 at idx i.
- equal  out  1  (tt1 == tt2); valid from done until the next start.
- mismatch_cnt  out  5  number of differing vectors; present with SWEEP_COMPARE_EN.
- first_mis  out  4  lowest differing idx; present with SWEEP_COMPARE_EN.
- first_valid  out  1  first_mis holds a valid index; present with SWEEP_COMPARE_EN.

## Operation
- State machine: IDLE, SETTLE, SAMPLE, DONE.
- Registers: idx (4 bits), settle counter cnt (4 bits).
- IDLE:
  - idx = 0, so w/x/y/z = 0.
  - start=1 → SETTLE, with idx←0, cnt←SETTLE_CYC-1.
  - start also clears tt1, tt2, mismatch_cnt and first_valid.
- SETTLE: if cnt==0 → SAMPLE; otherwise cnt←cnt-1.
- SAMPLE:
  - tt1[idx]←f1 and tt2[idx]←f2.
  - If f1≠f2: increment mismatch_cnt. If first_valid=0, also first_mis←idx and first_valid←1.
  - If idx==15 → DONE; otherwise idx←idx+1, cnt←SETTLE_CYC-1, → SETTLE.
- DONE: done=1 for this single cycle, then → IDLE.
- Outputs hold after a sweep: tt1, tt2, equal and the compare outputs keep their values until the next accepted start.
- start while busy or in DONE: ignored.
- abort in SETTLE or SAMPLE:
  - → IDLE next cycle; no done pulse.
  - Bits already sampled are kept; bits not yet sampled stay 0.
  - abort has priority over a same-cycle SAMPLE write; that write is suppressed.
- abort in IDLE or DONE: ignored.
- start and abort together in IDLE: start wins, because abort is ignored in IDLE.
- equal is combinational from tt1 and tt2.
- mismatch_cnt saturates at 16; this never wraps, since there are at most 16 vectors.

## Timing
- Reset values: state=IDLE, idx=0, w=x=y=z=0, busy=0, done=0, tt1=tt2=0, equal=1, mismatch_cnt=0, first_mis=0, first_valid=0.
- Reset asserted mid-sweep: all of the above are restored immediately (asynchronous). No done pulse is produced.
- Per-vector time: SETTLE_CYC+1 cycles (SETTLE_CYC cycles in SETTLE, 1 in SAMPLE).
- Start acceptance: start is accepted at rising edge E; busy rises after E.
- Sweep end: the last SAMPLE occupies the cycle ending at edge E+16·(SETTLE_CYC+1). done is high in the following cycle. Total start-to-done latency is 16·(SETTLE_CYC+1) cycles.
- Back-to-back sweeps: after done, the earliest new start is accepted one cycle later, in IDLE.
- Vector timing: a vector changes only on the edge leaving SAMPLE. f1/f2 are sampled at least SETTLE_CYC cycles after the vector was applied.

## Configuration
- SWEEP_COMPARE_EN defined: mismatch_cnt, first_mis and first_valid are implemented exactly as described above.
- SWEEP_COMPARE_EN undefined:
  - Those three ports remain on the interface but are tied to 0, and no compare logic is built.
  - equal remains functional.

## Structure
- Shared package sweep_pkg holds:
  - the state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3);
  - NUM_VEC=16;
  - IDX_W=4;
  - CNT_W=4.
- One sub-module, sweep_settle_cnt: loadable down-counter with a zero flag, used for the settle wait.
- All other logic is in truth_table_sweeper.

## Test plan
- Example SOP/POS pair as DUT, SETTLE_CYC=1, start pulse:
  - tt1=16'h324E and tt2=16'h32EE;
  - equal=0, mismatch_cnt=2, first_mis=5, first_valid=1;
  - done exactly 32 cycles after start is accepted.
- Bench drives f1=f2=w, SETTLE_CYC=3: tt1=tt2=16'hFF00, equal=1, mismatch_cnt=0, first_valid=0, done at 64 cycles.
- abort asserted during the SAMPLE of idx=6, with f1=1 and f2=0 throughout:
  - FSM is in IDLE the next cycle; tt1=16'h003F; no done pulse; mismatch_cnt=6.
  - A new start clears all results.
- start held high for the entire sweep: exactly one sweep and one done pulse. A second sweep begins only after IDLE is re-entered with start still high.
- rst asserted asynchronously mid-SETTLE at idx=9: all outputs return to their reset values without waiting for a clock edge.
- Build without SWEEP_COMPARE_EN, using the same stimulus as the first scenario: mismatch_cnt, first_mis and first_valid are 0, while equal=0 and tt1/tt2 are unchanged.

Source files
------------

// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_pkg
//  Description : Shared types and sizing constants for the truth-table
//                sweeper: FSM state encoding, vector count and the widths
//                of the vector index and settle counter.
//  Revision    : 1.0  initial release
// ============================================================================
package sweep_pkg;

    localparam int NUM_VEC = 16;   // 4-input block -> 16 input vectors
    localparam int IDX_W   = 4;    // vector index width
    localparam int CNT_W   = 4;    // settle counter width
    localparam int MIS_W   = 5;    // mismatch count must reach 16

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage : sweep_pkg
`default_nettype wire

// File: rtl/sweep_settle_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_settle_cnt
//  Description : Loadable down-counter with a zero flag. Counts the settle
//                cycles each vector is held before its outputs are sampled.
//                The count stops at zero rather than wrapping.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                load_i     - load load_val_i (has priority over dec_i)
//                load_val_i - value to load
//                dec_i      - decrement by one when non-zero
//                zero_o     - count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module sweep_settle_cnt
    import sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : sweep_settle_cnt
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Drives a 4-input combinational block through all 16 input
//                vectors ({w,x,y,z} = idx, w is MSB), holds each vector for
//                SETTLE_CYC cycles, then captures f1/f2 into the tt1/tt2
//                truth tables. equal reports tt1 == tt2.
//  Macro       : SWEEP_COMPARE_EN - when defined, builds the per-vector
//                compare logic (mismatch_cnt, first_mis, first_valid);
//                otherwise those outputs are tied to 0.
//  Parameters  : SETTLE_CYC   - cycles each vector is held (legal 1..15)
//  Ports       : clk, rst     - clock (rising edge), async active-high reset
//                start        - begin a sweep (accepted only in IDLE)
//                abort        - stop a running sweep, no done pulse
//                f1, f2       - outputs of the block under test
//                w, x, y, z   - applied vector
//                busy         - sweep in progress
//                done         - one-cycle pulse on sweep completion
//                tt1, tt2     - captured truth tables, bit i = f at idx i
//                equal        - tt1 == tt2
//                mismatch_cnt - number of differing vectors
//                first_mis    - lowest differing idx
//                first_valid  - first_mis is valid
//  Revision    : 1.0  initial release
// ============================================================================
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             f1,
    input  logic             f2,
    output logic             w,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [15:0]      tt1,
    output logic [15:0]      tt2,
    output logic             equal,
    output logic [MIS_W-1:0] mismatch_cnt,
    output logic [IDX_W-1:0] first_mis,
    output logic             first_valid
);

    // Settle counter is loaded with SETTLE_CYC-1 so that SETTLE lasts
    // exactly SETTLE_CYC cycles (it exits on the cycle the count is zero).
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      tt1_q;
    logic [15:0]      tt2_q;

    logic             w_start_acc;
    logic             w_sample_wr;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;

    // Abort outranks the SAMPLE write, so a sample is only committed when
    // abort is low in that cycle.
    assign w_start_acc = (state_q == IDLE) && start;
    assign w_sample_wr = (state_q == SAMPLE) && !abort;
    assign w_cnt_load  = w_start_acc || (w_sample_wr && (idx_q != LAST_IDX));
    assign w_cnt_dec   = (state_q == SETTLE) && !abort;

    sweep_settle_cnt u_settle_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_cnt_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (w_cnt_dec),
        .zero_o     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt1_q   <= '0;
            tt2_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_start_acc) begin
                        state_q <= SETTLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        tt1_q   <= '0;
                        tt2_q   <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (w_cnt_zero) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (w_sample_wr) begin
                        tt1_q[idx_q] <= f1;
                        tt2_q[idx_q] <= f2;
                        // Wraps 15 -> 0, leaving the vector at 0 after the sweep.
                        idx_q        <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SETTLE;
                        end
                    end else begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {w, x, y, z} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tt1          = tt1_q;
    assign tt2          = tt2_q;
    assign equal        = (tt1_q == tt2_q);

`ifdef SWEEP_COMPARE_EN
    localparam logic [MIS_W-1:0] MIS_SAT = MIS_W'(NUM_VEC);

    logic [MIS_W-1:0] mis_cnt_q;
    logic [IDX_W-1:0] first_mis_q;
    logic             first_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_cnt_q     <= '0;
            first_mis_q   <= '0;
            first_valid_q <= 1'b0;
        end else if (w_start_acc) begin
            // first_mis is left as-is; first_valid qualifies it.
            mis_cnt_q     <= '0;
            first_valid_q <= 1'b0;
        end else if (w_sample_wr && (f1 != f2)) begin
            if (mis_cnt_q != MIS_SAT) begin
                mis_cnt_q <= mis_cnt_q + MIS_W'(1);
            end
            if (!first_valid_q) begin
                first_mis_q   <= idx_q;
                first_valid_q <= 1'b1;
            end
        end
    end

    assign mismatch_cnt = mis_cnt_q;
    assign first_mis    = first_mis_q;
    assign first_valid  = first_valid_q;
`else
    assign mismatch_cnt = '0;
    assign first_mis    = '0;
    assign first_valid  = 1'b0;
`endif

endmodule : truth_table_sweeper
`default_nettype wire
